// File: rtl/reg_wb_queue_if.sv
// Writeback queue bus: request push side, register file drain side, two bypass lookup ports.
// The producer/bench drives through master; the queue implements slave.
interface reg_wb_queue_if #(
  parameter int AW = 2
);
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_wn;
  logic [31:0] in_wd;
  logic        wb_hold;

  logic        RegWrite;
  logic [4:0]  WN;
  logic [31:0] WD;

  logic [4:0]  lk_rn1;
  logic        lk_hit1;
  logic [31:0] lk_data1;
  logic [4:0]  lk_rn2;
  logic        lk_hit2;
  logic [31:0] lk_data2;

  logic [AW:0] count;
  logic        empty;

  modport master (
    output in_valid, in_wn, in_wd, wb_hold, lk_rn1, lk_rn2,
    input  in_ready, RegWrite, WN, WD, lk_hit1, lk_data1, lk_hit2, lk_data2, count, empty
  );

  modport slave (
    input  in_valid, in_wn, in_wd, wb_hold, lk_rn1, lk_rn2,
    output in_ready, RegWrite, WN, WD, lk_hit1, lk_data1, lk_hit2, lk_data2, count, empty
  );
endinterface

// File: rtl/reg_wb_queue.sv
// Register-file writeback FIFO with youngest-match bypass lookups; WB_INPUT_FWD_EN adds the accepted request to lookups.
// Latency: accept at edge N, write at edge N+1 (wb_hold stalls drain); in_ready = count < DEPTH, independent of same-cycle pop.
module reg_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic          clk,
  input logic          reset,
  reg_wb_queue_if.slave bus
);

  typedef struct packed {
    logic [4:0]  wn;
    logic [31:0] wd;
  } ent_t;

  ent_t        mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;

  logic empty;
  logic full;
  logic push;
  logic pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  // Register 0 is hardwired, so such writes are accepted but never stored.
  assign push  = bus.in_valid && !full && (bus.in_wn != 5'd0);
  assign pop   = !empty && !bus.wb_hold;

  assign bus.in_ready = !full;
  assign bus.count    = count;
  assign bus.empty    = empty;
  assign bus.RegWrite = pop;
  assign bus.WN       = empty ? 5'd0  : mem[head].wn;
  assign bus.WD       = empty ? 32'd0 : mem[head].wd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  // Payload storage needs no reset: occupancy gates every read of it.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= '{wn: bus.in_wn, wd: bus.in_wd};
  end

  logic        fwd_hit1;
  logic        fwd_hit2;
`ifdef WB_INPUT_FWD_EN
  assign fwd_hit1 = push && (bus.in_wn == bus.lk_rn1);
  assign fwd_hit2 = push && (bus.in_wn == bus.lk_rn2);
`else
  assign fwd_hit1 = 1'b0;
  assign fwd_hit2 = 1'b0;
`endif

  logic        hit1;
  logic        hit2;
  logic [31:0] data1;
  logic [31:0] data2;

  // Scan oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [AW-1:0] idx;
    idx   = head;
    hit1  = 1'b0;
    hit2  = 1'b0;
    data1 = 32'd0;
    data2 = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if ((AW+1)'(i) < count) begin
        if ((bus.lk_rn1 != 5'd0) && (mem[idx].wn == bus.lk_rn1)) begin
          hit1  = 1'b1;
          data1 = mem[idx].wd;
        end
        if ((bus.lk_rn2 != 5'd0) && (mem[idx].wn == bus.lk_rn2)) begin
          hit2  = 1'b1;
          data2 = mem[idx].wd;
        end
      end
    end
    if (fwd_hit1) begin
      hit1  = 1'b1;
      data1 = bus.in_wd;
    end
    if (fwd_hit2) begin
      hit2  = 1'b1;
      data2 = bus.in_wd;
    end
  end

  assign bus.lk_hit1  = hit1;
  assign bus.lk_data1 = data1;
  assign bus.lk_hit2  = hit2;
  assign bus.lk_data2 = data2;

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed vector bench for reg_wb_queue: per-cycle table plus reset and forwarding sequences.
module tb_reg_wb_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  reg_wb_queue_if #(.AW(AW)) bus ();

  reg_wb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [4:0]  wn;
    logic [31:0] wd;
    logic        hold;
    logic [4:0]  rn1;
    logic [4:0]  rn2;
    logic        rdy;
    logic        rw;
    logic [4:0]  ewn;
    logic [31:0] ewd;
    logic        h1;
    logic [31:0] d1;
    logic        h2;
    logic [31:0] d2;
    logic [AW:0] cnt;
    logic        emp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic vld, input logic [4:0] wn, input logic [31:0] wd, input logic hold,
                     input logic [4:0] rn1, input logic [4:0] rn2,
                     input logic rdy, input logic rw, input logic [4:0] ewn, input logic [31:0] ewd,
                     input logic h1, input logic [31:0] d1, input logic h2, input logic [31:0] d2,
                     input logic [AW:0] cnt, input logic emp);
    vec_t v;
    v.vld = vld; v.wn = wn; v.wd = wd; v.hold = hold; v.rn1 = rn1; v.rn2 = rn2;
    v.rdy = rdy; v.rw = rw; v.ewn = ewn; v.ewd = ewd; v.h1 = h1; v.d1 = d1;
    v.h2 = h2; v.d2 = d2; v.cnt = cnt; v.emp = emp;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [4:0] wn, input logic [31:0] wd,
                       input logic hold, input logic [4:0] rn1, input logic [4:0] rn2);
    bus.in_valid = vld;
    bus.in_wn    = wn;
    bus.in_wd    = wd;
    bus.wb_hold  = hold;
    bus.lk_rn1   = rn1;
    bus.lk_rn2   = rn2;
  endtask

  initial begin
    //  vld wn  wd            hold rn1 rn2 | rdy rw WN  WD            h1 d1            h2 d2            cnt emp
    add(0, 0, 0,            0, 5, 0,     1, 0, 0, 0,            0, 0,            0, 0,            0, 1);
    add(1, 3, 32'hDEADBEEF, 0, 5, 0,     1, 0, 0, 0,            0, 0,            0, 0,            0, 1);
    add(0, 0, 0,            0, 3, 3,     1, 1, 3, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1, 0);
    add(0, 0, 0,            0, 3, 0,     1, 0, 0, 0,            0, 0,            0, 0,            0, 1);
    add(1, 1, 10,           1, 0, 0,     1, 0, 0, 0,            0, 0,            0, 0,            0, 1);
    add(1, 2, 20,           1, 1, 0,     1, 0, 1, 10,           1, 10,           0, 0,            1, 0);
    add(1, 3, 30,           1, 2, 0,     1, 0, 1, 10,           1, 20,           0, 0,            2, 0);
    add(1, 4, 40,           1, 3, 0,     1, 0, 1, 10,           1, 30,           0, 0,            3, 0);
    add(1, 5, 50,           1, 4, 5,     0, 0, 1, 10,           1, 40,           0, 0,            4, 0);
    add(1, 6, 60,           0, 1, 6,     0, 1, 1, 10,           1, 10,           0, 0,            4, 0);
    add(0, 0, 0,            0, 1, 6,     1, 1, 2, 20,           0, 0,            0, 0,            3, 0);
    add(0, 0, 0,            0, 4, 2,     1, 1, 3, 30,           1, 40,           0, 0,            2, 0);
    add(0, 0, 0,            0, 4, 5,     1, 1, 4, 40,           1, 40,           0, 0,            1, 0);
    add(0, 0, 0,            0, 4, 0,     1, 0, 0, 0,            0, 0,            0, 0,            0, 1);
    add(1, 7, 100,          1, 5, 0,     1, 0, 0, 0,            0, 0,            0, 0,            0, 1);
    add(1, 7, 200,          1, 9, 0,     1, 0, 7, 100,          0, 0,            0, 0,            1, 0);
    add(0, 0, 0,            1, 7, 7,     1, 0, 7, 100,          1, 200,          1, 200,          2, 0);
    add(0, 0, 0,            0, 7, 0,     1, 1, 7, 100,          1, 200,          0, 0,            2, 0);
    add(0, 0, 0,            0, 7, 0,     1, 1, 7, 200,          1, 200,          0, 0,            1, 0);
    add(0, 0, 0,            0, 7, 0,     1, 0, 0, 0,            0, 0,            0, 0,            0, 1);
    add(1, 0, 123,          0, 0, 0,     1, 0, 0, 0,            0, 0,            0, 0,            0, 1);
    add(0, 0, 0,            0, 0, 0,     1, 0, 0, 0,            0, 0,            0, 0,            0, 1);
    add(1, 8, 80,           0, 5, 0,     1, 0, 0, 0,            0, 0,            0, 0,            0, 1);
    add(1, 9, 90,           0, 8, 0,     1, 1, 8, 80,           1, 80,           0, 0,            1, 0);
    add(0, 0, 0,            0, 9, 8,     1, 1, 9, 90,           1, 90,           0, 0,            1, 0);
    add(0, 0, 0,            0, 9, 0,     1, 0, 0, 0,            0, 0,            0, 0,            0, 1);

    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].vld, vecs[i].wn, vecs[i].wd, vecs[i].hold, vecs[i].rn1, vecs[i].rn2);
      #1;
      chk($sformatf("row%0d in_ready", i), 32'(bus.in_ready), 32'(vecs[i].rdy));
      chk($sformatf("row%0d RegWrite", i), 32'(bus.RegWrite), 32'(vecs[i].rw));
      chk($sformatf("row%0d WN", i),       32'(bus.WN),       32'(vecs[i].ewn));
      chk($sformatf("row%0d WD", i),       bus.WD,            vecs[i].ewd);
      chk($sformatf("row%0d lk_hit1", i),  32'(bus.lk_hit1),  32'(vecs[i].h1));
      chk($sformatf("row%0d lk_data1", i), bus.lk_data1,      vecs[i].d1);
      chk($sformatf("row%0d lk_hit2", i),  32'(bus.lk_hit2),  32'(vecs[i].h2));
      chk($sformatf("row%0d lk_data2", i), bus.lk_data2,      vecs[i].d2);
      chk($sformatf("row%0d count", i),    32'(bus.count),    32'(vecs[i].cnt));
      chk($sformatf("row%0d empty", i),    32'(bus.empty),    32'(vecs[i].emp));
    end

    // Same-cycle visibility of the request being accepted
    @(negedge clk);
    drive(1, 9, 55, 0, 9, 0);
    #1;
`ifdef WB_INPUT_FWD_EN
    chk("fwd lk_hit1", 32'(bus.lk_hit1), 32'd1);
    chk("fwd lk_data1", bus.lk_data1, 32'd55);
`else
    chk("nofwd lk_hit1", 32'(bus.lk_hit1), 32'd0);
    chk("nofwd lk_data1", bus.lk_data1, 32'd0);
`endif
    @(negedge clk);
    drive(0, 0, 0, 0, 9, 0);
    #1;
    chk("fwd drain RegWrite", 32'(bus.RegWrite), 32'd1);
    chk("fwd drain WD", bus.WD, 32'd55);
    chk("fwd drain lk_data1", bus.lk_data1, 32'd55);

    // Asynchronous reset with three pending entries
    @(negedge clk);
    drive(1, 11, 1, 1, 0, 0);
    @(negedge clk);
    drive(1, 12, 2, 1, 0, 0);
    @(negedge clk);
    drive(1, 13, 3, 1, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 12, 0);
    #1;
    chk("pre-reset count", 32'(bus.count), 32'd3);
    chk("pre-reset RegWrite", 32'(bus.RegWrite), 32'd1);
    chk("pre-reset WN", 32'(bus.WN), 32'd11);
    chk("pre-reset lk_data1", bus.lk_data1, 32'd2);
    #1;
    reset = 1'b1;
    #1;
    chk("async reset count", 32'(bus.count), 32'd0);
    chk("async reset RegWrite", 32'(bus.RegWrite), 32'd0);
    chk("async reset empty", 32'(bus.empty), 32'd1);
    chk("async reset lk_hit1", 32'(bus.lk_hit1), 32'd0);
    chk("async reset WN", 32'(bus.WN), 32'd0);
    chk("async reset WD", bus.WD, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("post-reset%0d RegWrite", k), 32'(bus.RegWrite), 32'd0);
      chk($sformatf("post-reset%0d count", k), 32'(bus.count), 32'd0);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
